// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared state type and default address map for the pattern scan controller.
package pattern_scan_ctrl_pkg;

  localparam int unsigned DefNBytes  = 32;
  localparam int unsigned DefPatAddr = 32;
  localparam int unsigned DefResAddr = 33;

  typedef enum logic [2:0] {
    StIdle,
    StRdPat,
    StScan,
    StWr0,
    StWr1,
    StWr2,
    StDone
  } state_e;

endpackage

// File: rtl/pattern_match_unit.sv
// Counts 5-bit pattern matches in a 12-bit window: {previous byte low nibble, current byte}.
module pattern_match_unit (
  input  logic [11:0] window_i,
  input  logic [4:0]  pattern_i,
  output logic [2:0]  in_cnt_o,
  output logic        any_match_o,
  output logic [2:0]  straddle_cnt_o
);

  always_comb begin
    in_cnt_o       = '0;
    straddle_cnt_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (window_i[i +: 5] == pattern_i) in_cnt_o = in_cnt_o + 3'd1;
      // Windows starting in the carried nibble straddle the byte boundary
      if (window_i[i + 4 +: 5] == pattern_i) straddle_cnt_o = straddle_cnt_o + 3'd1;
    end
    any_match_o = (in_cnt_o != 3'd0);
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scans N_BYTES message bytes for a 5-bit pattern and writes three match counts back to memory.
// Build option: define PSCAN_CYCLE_CNT_EN to add the 16-bit cycle_cnt output.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int unsigned N_BYTES  = DefNBytes,
  parameter int unsigned PAT_ADDR = DefPatAddr,
  parameter int unsigned RES_ADDR = DefResAddr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        busy,
  output logic [7:0]  mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data
`ifdef PSCAN_CYCLE_CNT_EN
  ,
  output logic [15:0] cycle_cnt
`endif
);

  localparam logic [7:0] LastK   = 8'(N_BYTES);
  localparam logic [7:0] PatAddr = 8'(PAT_ADDR);
  localparam logic [7:0] ResAddr = 8'(RES_ADDR);

  state_e     state_q;
  logic [7:0] k_q;
  logic [4:0] pat_q;
  logic [3:0] carry_q;
  logic [7:0] ctb_q, cto_q, cts_q;
  logic [7:0] ctb_d, cto_d, cts_d;
  logic [2:0] in_cnt, straddle_cnt;
  logic       any_match;

  pattern_match_unit u_match (
    .window_i       ({carry_q, mem_rd_data}),
    .pattern_i      (pat_q),
    .in_cnt_o       (in_cnt),
    .any_match_o    (any_match),
    .straddle_cnt_o (straddle_cnt)
  );

  always_comb begin
    ctb_d = ctb_q + {5'd0, in_cnt};
    cto_d = cto_q + {7'd0, any_match};
    cts_d = cts_q + {5'd0, in_cnt};
    // Byte 0 has no predecessor, so its straddle windows do not exist
    if (k_q >= 8'd2) cts_d = cts_d + {5'd0, straddle_cnt};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      k_q         <= '0;
      pat_q       <= '0;
      carry_q     <= '0;
      ctb_q       <= '0;
      cto_q       <= '0;
      cts_q       <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StRdPat;
            k_q       <= '0;
            carry_q   <= '0;
            ctb_q     <= '0;
            cto_q     <= '0;
            cts_q     <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            mem_addr  <= PatAddr;
            mem_rd_en <= 1'b1;
          end
        end
        StRdPat: begin
          state_q   <= StScan;
          k_q       <= '0;
          mem_addr  <= '0;
          mem_rd_en <= 1'b1;
        end
        StScan: begin
          // Read data in cycle k belongs to the address issued in cycle k-1
          if (k_q == 8'd0) begin
            pat_q <= mem_rd_data[7:3];
          end else begin
            ctb_q   <= ctb_d;
            cto_q   <= cto_d;
            cts_q   <= cts_d;
            carry_q <= mem_rd_data[3:0];
          end
          if (k_q == LastK) begin
            state_q     <= StWr0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b1;
            mem_addr    <= ResAddr;
            mem_wr_data <= ctb_d;
          end else begin
            k_q <= k_q + 8'd1;
            if (k_q + 8'd1 < LastK) mem_addr <= k_q + 8'd1;
            else                    mem_rd_en <= 1'b0;
          end
        end
        StWr0: begin
          state_q     <= StWr1;
          mem_addr    <= ResAddr + 8'd1;
          mem_wr_data <= cto_q;
        end
        StWr1: begin
          state_q     <= StWr2;
          mem_addr    <= ResAddr + 8'd2;
          mem_wr_data <= cts_q;
        end
        StWr2: begin
          state_q     <= StDone;
          mem_wr_en   <= 1'b0;
          mem_addr    <= '0;
          mem_wr_data <= '0;
          busy        <= 1'b0;
          done        <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PSCAN_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_q;

  // Counts the edges from the accepted start up to the last result write
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
    end else if ((state_q == StIdle || state_q == StDone) && start) begin
      cycle_cnt_q <= '0;
    end else if (busy && state_q != StWr2) begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule
